spi_slave_regs: RTL and testbench
=================================

# spi_slave_regs

SPI responder with an 8-bit register file, clocked by the fabric clock: the slave end of the serial control protocol that the design's SPI masters drive (for example the BOS control port `sl`/`sck`/`sdatai`/`sdatao`). It oversamples the slave-side `n_cs`, `sclk` and `mosi`, decodes a two-byte command and serves reads on `miso`. It exposes the register contents and write strobes to the fabric. It is used as an on-board loopback target for the master interfaces and as the behavioural slave in their benches.

## Interface
Parameters:
- `N_REGS`, 16: number of 8-bit registers, 1..128.
- `CPOL`, 0: idle level of `sclk`. Clock phase is fixed at CPHA=0.

Ports:
- `clk`  in  1  fabric clock (`fpga_clk_48`).
- `rst`  in  1  synchronous, active-high reset.
- `n_cs`  in  1  slave select, active low, asynchronous to `clk`.
- `sclk`  in  1  serial clock, asynchronous to `clk`.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first; 0 whenever `n_cs`=1.
- `regs`  out  8*N_REGS  register file, flattened; reg i is at `[8*i+:8]`.
- `wr_stb`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  7  address of the last write.
- `wr_data`  out  8  data of the last write.
- `rd_stb`  out  1  one-cycle pulse when a read command is decoded.
- `busy`  out  1  high while a transaction is in progress.

## Operation
- Frame is 16 bits with `n_cs` low. Byte 0 is the command `{rw, addr[6:0]}`, where rw=1 means read. Byte 1 is data: write data on `mosi` for writes, register contents on `miso` for reads.
- Input conditioning: `n_cs`, `sclk` and `mosi` each pass through a 2-flop synchronizer, followed by edge detection on synchronized `sclk` and `n_cs`.
- Edge roles:
  - Sample edge is the leading edge: rising when CPOL=0, falling when CPOL=1. `mosi` is shifted in on this edge.
  - Shift edge is the trailing edge. `miso` updates on this edge.
- Bit counter: 4 bits, reset to 0 on the `n_cs` falling edge, incremented on each sample edge.
- State machine:
  - IDLE -> CMD on `n_cs` falling edge.
  - CMD -> DATA after the 8th sample edge. On that edge, latch the command; if rw=1, load the read shifter and pulse `rd_stb`.
  - DATA -> DONE after the 16th sample edge. If rw=0 and addr < N_REGS, write the register and pulse `wr_stb`.
  - DONE ignores further `sclk` edges; `miso`=0.
  - Any state -> IDLE on the `n_cs` rising edge.
- Read source: `regs[addr]` when addr < N_REGS, otherwise 0x00. The value is captured once at the 8th sample edge, so a concurrent fabric write does not alter the byte being shifted out.
- `miso` during CMD is 0. Bit 7 of the read data appears on the 8th shift edge, bits 6..0 on the following shift edges. For a write frame `miso` stays 0.
- Abort: `n_cs` rising before the 16th sample edge discards the frame. No write, no `wr_stb`. A `rd_stb` already issued stands.
- Out-of-range write: no register changes and no `wr_stb`. `wr_addr` and `wr_data` are unchanged.
- Reset mid-frame: FSM returns to IDLE. The next frame starts only at a new `n_cs` falling edge; the remaining bits of the interrupted frame are ignored.
- `sclk` edges while `n_cs`=1 are ignored.

## Timing
- Reset values:
  - `regs` all 0x00, `miso` 0, `wr_stb` 0, `rd_stb` 0, `busy` 0.
  - `wr_addr` 0, `wr_data` 0, FSM in IDLE.
- Input latency: 2 `clk` cycles of synchronization plus 1 cycle of edge detection.
- `wr_stb`, `regs` update, `wr_addr`/`wr_data` update: all in the same cycle, 3 `clk` after the raw 16th sample edge.
- `rd_stb`: 3 `clk` after the raw 8th sample edge.
- `miso` is registered and changes 3 `clk` after the raw shift edge, so the master sees a 3-cycle delay.
- `busy` rises 3 `clk` after `n_cs` falls and drops 3 `clk` after `n_cs` rises.
- Constraints:
  - Each `sclk` phase must be at least 4 `clk` long, so `sclk` ≤ `clk`/8 (6 MHz at 48 MHz).
  - `n_cs` setup and hold to `sclk` must each be at least 4 `clk`.
  - Violating these constraints is unsupported; the only requirement is that the block never locks up and recovers at the next `n_cs` falling edge.

## Structure
- Shared package `spi_slave_pkg`:
  - state enum `IDLE`/`CMD`/`DATA`/`DONE`;
  - `ADDR_W`=7;
  - `RW_BIT`=7;
  - `FRAME_BITS`=16.
- One sub-module, `sync_edge`: 2-flop synchronizer with rising/falling pulse outputs. Instantiated for `sclk` and `n_cs`; `mosi` uses the synchronizer only.

## Test plan
- Write: CPOL=0, `sclk` = `clk`/8, frame 0x05 0xA5 -> `wr_stb` for one cycle, `wr_addr`=0x05, `wr_data`=0xA5, `regs[47:40]`=0xA5, `miso`=0 throughout.
- Readback: after the write, frame 0x85 0x00 -> `rd_stb` pulse, `miso` byte 1 = 0xA5, all registers unchanged.
- Out of range (N_REGS=16): write 0x20 0xFF -> no `wr_stb`, `regs` unchanged. Read 0xA0 -> `miso` = 0x00.
- Abort: write 0x03 0x5A with `n_cs` raised after the 12th bit -> no `wr_stb`, reg 3 = 0x00. Next full frame 0x03 0x5A writes correctly.
- CPOL=1: same write and read frames with idle-high `sclk` -> results identical to the CPOL=0 scenarios.
- Reset mid-frame: assert `rst` during bit 10 of a write, release it, finish that frame, then send a fresh frame 0x01 0x11 -> all outputs at reset values, no write from the interrupted frame, reg 1 = 0x11.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants and FSM state encoding for the SPI register responder.
package spi_slave_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spi_slave_regs_sync_edge.sv
// Two-flop synchronizer with single-cycle rising/falling pulses on the synchronized level.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [2:0] pipe_q;

  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= {3{RST_VAL}};
    end else begin
      pipe_q <= {pipe_q[1:0], d_i};
    end
  end

  assign rise_c_o = pipe_q[1] & ~pipe_q[2];
  assign fall_c_o = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder (CPHA=0) with an 8-bit register file, oversampled on the fabric clock.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int unsigned N_REGS = 16,
  parameter int unsigned CPOL   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    n_cs,
  input  logic                    sclk,
  input  logic                    mosi,
  output logic                    miso,
  output logic [8*N_REGS-1:0]     regs,
  output logic                    wr_stb,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [BYTE_W-1:0]       wr_data,
  output logic                    rd_stb,
  output logic                    busy
);

  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(N_REGS);

  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic sample_c, shift_c;
  logic mosi_meta_q, mosi_sync_q;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-2:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic [BYTE_W-1:0]   rd_shift_q, rd_shift_d;
  logic                miso_q, miso_d;
  logic [8*N_REGS-1:0] regs_q, regs_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic                rd_stb_q, rd_stb_d;
  logic                busy_q, busy_d;

  logic [BYTE_W-1:0]   rx_byte_c;
  logic [BYTE_W-1:0]   rd_val_c;
  logic                wr_en_c;

  // sclk sync resets to its idle level; n_cs sync resets to "selected" so a frame
  // interrupted by reset cannot restart until n_cs genuinely goes high then low again
  sync_edge #(.RST_VAL(1'(CPOL))) u_sync_sclk (
    .clk      (clk),
    .rst      (rst),
    .d_i      (sclk),
    .rise_c_o (sclk_rise_c),
    .fall_c_o (sclk_fall_c)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
    .clk      (clk),
    .rst      (rst),
    .d_i      (n_cs),
    .rise_c_o (cs_rise_c),
    .fall_c_o (cs_fall_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sample_c  = (CPOL != 0) ? sclk_fall_c : sclk_rise_c;
  assign shift_c   = (CPOL != 0) ? sclk_rise_c : sclk_fall_c;
  assign rx_byte_c = {shift_q, mosi_sync_q};
  assign wr_en_c   = ~cmd_q[RW_BIT] && ({1'b0, cmd_q[ADDR_W-1:0]} < NREGS_L);

  // Read source: addressed register, or zero when out of range
  always_comb begin
    rd_val_c = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (rx_byte_c[ADDR_W-1:0] == ADDR_W'(i)) begin
        rd_val_c = regs_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    rd_shift_d = rd_shift_q;
    miso_d     = miso_q;
    regs_d     = regs_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_stb_d   = 1'b0;

    if (cs_rise_c) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else if (cs_fall_c) begin
      state_d = CMD;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          miso_d = 1'b0;
          if (sample_c) begin
            shift_d = rx_byte_c[BYTE_W-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BYTE_W-1)) begin
              state_d = DATA;
              cmd_d   = rx_byte_c;
              if (rx_byte_c[RW_BIT]) begin
                rd_shift_d = rd_val_c;
                rd_stb_d   = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (shift_c && cmd_q[RW_BIT]) begin
            miso_d     = rd_shift_q[BYTE_W-1];
            rd_shift_d = {rd_shift_q[BYTE_W-2:0], 1'b0};
          end
          if (sample_c) begin
            shift_d = rx_byte_c[BYTE_W-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS-1)) begin
              state_d = DONE;
              if (wr_en_c) begin
                for (int unsigned i = 0; i < N_REGS; i++) begin
                  if (cmd_q[ADDR_W-1:0] == ADDR_W'(i)) begin
                    regs_d[8*i +: 8] = rx_byte_c;
                  end
                end
                wr_stb_d  = 1'b1;
                wr_addr_d = cmd_q[ADDR_W-1:0];
                wr_data_d = rx_byte_c;
              end
            end
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      rd_shift_q <= '0;
      miso_q     <= 1'b0;
      regs_q     <= '0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      rd_shift_q <= rd_shift_d;
      miso_q     <= miso_d;
      regs_q     <= regs_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_stb_q   <= rd_stb_d;
      busy_q     <= busy_d;
    end
  end

  assign miso    = miso_q;
  assign regs    = regs_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_stb  = rd_stb_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench: CPOL=0 and CPOL=1 instances driven by the same frames (sclk1 = ~sclk0).
module tb_spi_slave_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, n_cs, sclk0, sclk1, mosi;
  assign sclk1 = ~sclk0;

  logic         miso    [2];
  logic [127:0] regs    [2];
  logic         wr_stb  [2];
  logic [6:0]   wr_addr [2];
  logic [7:0]   wr_data [2];
  logic         rd_stb  [2];
  logic         busy    [2];

  spi_slave_regs #(.N_REGS(16), .CPOL(0)) dut0 (
    .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk0), .mosi(mosi),
    .miso(miso[0]), .regs(regs[0]), .wr_stb(wr_stb[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .rd_stb(rd_stb[0]), .busy(busy[0])
  );

  spi_slave_regs #(.N_REGS(16), .CPOL(1)) dut1 (
    .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk1), .mosi(mosi),
    .miso(miso[1]), .regs(regs[1]), .wr_stb(wr_stb[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .rd_stb(rd_stb[1]), .busy(busy[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cumulative strobe/miso activity, sampled mid-cycle
  int wr_cnt [2] = '{0, 0};
  int rd_cnt [2] = '{0, 0};
  int mhi_cnt[2] = '{0, 0};
  int wr_cyc [2] = '{0, 0};
  int rd_cyc [2] = '{0, 0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_stb[d]) begin wr_cnt[d]++; wr_cyc[d] = cyc; end
      if (rd_stb[d]) begin rd_cnt[d]++; rd_cyc[d] = cyc; end
      if (miso[d]) mhi_cnt[d]++;
    end
  end

  int checks = 0;
  int failures = 0;

  logic [15:0]  rx      [2];
  logic         bmid    [2];
  int           d_wr    [2];
  int           d_rd    [2];
  int           d_mhi   [2];
  int           raw_wr_cyc, raw_rd_cyc;
  logic [127:0] exp_regs;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame; sclk phases are 4 clk. nbits<16 aborts; rst pulses during bit rst_bit.
  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input int nbits, input int rst_bit);
    logic [15:0] tx;
    int wr0[2], rd0[2], mh0[2];
    tx = {b0, b1};
    for (int d = 0; d < 2; d++) begin
      wr0[d] = wr_cnt[d]; rd0[d] = rd_cnt[d]; mh0[d] = mhi_cnt[d];
      rx[d] = '0; bmid[d] = 1'b0;
    end
    @(negedge clk); n_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[15-i];
      if (i == rst_bit) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rx[d] = {rx[d][14:0], miso[d]};
        if (i == 4) bmid[d] = busy[d];
      end
      sclk0 = 1'b1;
      if (i == 7)  raw_rd_cyc = cyc;
      if (i == 15) raw_wr_cyc = cyc;
      repeat (4) @(negedge clk);
      sclk0 = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_cs = 1'b1; mosi = 1'b0;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      d_wr[d] = wr_cnt[d] - wr0[d];
      d_rd[d] = rd_cnt[d] - rd0[d];
      d_mhi[d] = mhi_cnt[d] - mh0[d];
    end
  endtask

  initial begin
    rst = 1'b1; n_cs = 1'b1; sclk0 = 1'b0; mosi = 1'b0;
    exp_regs = '0;
    raw_wr_cyc = 0; raw_rd_cyc = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst regs", d),    regs[d],           128'h0);
      chk($sformatf("d%0d rst miso", d),    128'(miso[d]),     128'h0);
      chk($sformatf("d%0d rst wr_stb", d),  128'(wr_stb[d]),   128'h0);
      chk($sformatf("d%0d rst rd_stb", d),  128'(rd_stb[d]),   128'h0);
      chk($sformatf("d%0d rst busy", d),    128'(busy[d]),     128'h0);
      chk($sformatf("d%0d rst wr_addr", d), 128'(wr_addr[d]),  128'h0);
      chk($sformatf("d%0d rst wr_data", d), 128'(wr_data[d]),  128'h0);
    end

    // Write 0x05 <- 0xA5
    frame(8'h05, 8'hA5, 16, -1);
    exp_regs[47:40] = 8'hA5;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d w5 wr_stb count", d), 128'(d_wr[d]), 128'd1);
      chk($sformatf("d%0d w5 wr_stb latency", d), 128'(wr_cyc[d] - raw_wr_cyc), 128'd3);
      chk($sformatf("d%0d w5 wr_addr", d), 128'(wr_addr[d]), 128'h05);
      chk($sformatf("d%0d w5 wr_data", d), 128'(wr_data[d]), 128'hA5);
      chk($sformatf("d%0d w5 reg5", d), 128'(regs[d][47:40]), 128'hA5);
      chk($sformatf("d%0d w5 regs", d), regs[d], exp_regs);
      chk($sformatf("d%0d w5 miso quiet", d), 128'(d_mhi[d]), 128'd0);
      chk($sformatf("d%0d w5 rd_stb count", d), 128'(d_rd[d]), 128'd0);
      chk($sformatf("d%0d w5 busy mid", d), 128'(bmid[d]), 128'd1);
      chk($sformatf("d%0d w5 busy after", d), 128'(busy[d]), 128'd0);
    end

    // Read back 0x05
    frame(8'h85, 8'h00, 16, -1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d r5 rd_stb count", d), 128'(d_rd[d]), 128'd1);
      chk($sformatf("d%0d r5 rd_stb latency", d), 128'(rd_cyc[d] - raw_rd_cyc), 128'd3);
      chk($sformatf("d%0d r5 miso frame", d), 128'(rx[d]), 128'h00A5);
      chk($sformatf("d%0d r5 wr_stb count", d), 128'(d_wr[d]), 128'd0);
      chk($sformatf("d%0d r5 regs", d), regs[d], exp_regs);
    end

    // Out-of-range write and read
    frame(8'h20, 8'hFF, 16, -1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d w20 wr_stb count", d), 128'(d_wr[d]), 128'd0);
      chk($sformatf("d%0d w20 regs", d), regs[d], exp_regs);
      chk($sformatf("d%0d w20 wr_addr", d), 128'(wr_addr[d]), 128'h05);
      chk($sformatf("d%0d w20 wr_data", d), 128'(wr_data[d]), 128'hA5);
    end
    frame(8'hA0, 8'h00, 16, -1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d r20 miso frame", d), 128'(rx[d]), 128'h0000);
      chk($sformatf("d%0d r20 rd_stb count", d), 128'(d_rd[d]), 128'd1);
    end

    // Abort after 12 bits, then the full frame
    frame(8'h03, 8'h5A, 12, -1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d abort wr_stb count", d), 128'(d_wr[d]), 128'd0);
      chk($sformatf("d%0d abort reg3", d), 128'(regs[d][31:24]), 128'h00);
      chk($sformatf("d%0d abort busy", d), 128'(busy[d]), 128'd0);
    end
    frame(8'h03, 8'h5A, 16, -1);
    exp_regs[31:24] = 8'h5A;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d w3 wr_stb count", d), 128'(d_wr[d]), 128'd1);
      chk($sformatf("d%0d w3 regs", d), regs[d], exp_regs);
      chk($sformatf("d%0d w3 wr_addr", d), 128'(wr_addr[d]), 128'h03);
    end

    // Reset during bit 10 of a write; rest of that frame must be ignored
    frame(8'h07, 8'h77, 16, 10);
    exp_regs = '0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rstmid wr_stb count", d), 128'(d_wr[d]), 128'd0);
      chk($sformatf("d%0d rstmid regs", d), regs[d], exp_regs);
      chk($sformatf("d%0d rstmid wr_addr", d), 128'(wr_addr[d]), 128'h00);
      chk($sformatf("d%0d rstmid wr_data", d), 128'(wr_data[d]), 128'h00);
      chk($sformatf("d%0d rstmid busy", d), 128'(busy[d]), 128'd0);
      chk($sformatf("d%0d rstmid miso", d), 128'(miso[d]), 128'd0);
    end
    frame(8'h01, 8'h11, 16, -1);
    exp_regs[15:8] = 8'h11;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d w1 wr_stb count", d), 128'(d_wr[d]), 128'd1);
      chk($sformatf("d%0d w1 regs", d), regs[d], exp_regs);
    end
    frame(8'h81, 8'h00, 16, -1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d r1 miso frame", d), 128'(rx[d]), 128'h0011);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
